// File: rtl/receiver_if.sv
// Host/line-side signal bundle for the serial receiver.
// The slave modport is the receiver; the master modport is the line driver and host consumer.
interface receiver_if;
    logic       tick;
    logic       dataIn;
    logic       readAck;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       parityError;
    logic       framingError;
    logic       overrun;
    logic       busy;

    modport master (
        output tick, dataIn, readAck,
        input  dataOut, dataValid, parityError, framingError, overrun, busy
    );

    modport slave (
        input  tick, dataIn, readAck,
        output dataOut, dataValid, parityError, framingError, overrun, busy
    );
endinterface

// File: rtl/receiver.sv
// Oversampling receiver for 12-bit frames: start, 8 data LSB first, even parity, 2 stop bits.
// Each received byte is held behind a valid/acknowledge handshake with a sticky overrun flag.
module receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic        clk,
    input logic        reset,
    receiver_if.slave  bus
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            stop1_q, stop1_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            sample;
    logic            commit;

    logic [7:0] data_q;
    logic       valid_q, perr_q, ferr_q, ovr_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a spurious start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.dataIn};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            stop1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            stop1_q <= stop1_d;
        end
    end

    assign sample = (cnt_q == FullM1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        stop1_d = stop1_q;
        commit  = 1'b0;
        if (bus.tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    // Mid-bit recheck rejects glitches shorter than half a bit.
                    if (cnt_q == HalfM1) begin
                        if (!rx_s) begin
                            state_d = StData;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (sample) begin
                        shreg_d = {rx_s, shreg_q[7:1]};
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 3'd7) state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (sample) begin
                        par_d   = rx_s;
                        cnt_d   = '0;
                        state_d = StStop1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop1: begin
                    if (sample) begin
                        stop1_d = rx_s;
                        cnt_d   = '0;
                        state_d = StStop2;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop2: begin
                    if (sample) begin
                        commit  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A commit coinciding with readAck wins; the acknowledged byte is not counted as lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (commit) begin
            data_q  <= shreg_q;
            valid_q <= 1'b1;
            perr_q  <= (^shreg_q) != par_q;
            ferr_q  <= !stop1_q || !rx_s;
            if (bus.readAck)  ovr_q <= 1'b0;
            else if (valid_q) ovr_q <= 1'b1;
        end else if (bus.readAck && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign bus.dataOut      = data_q;
    assign bus.dataValid    = valid_q;
    assign bus.parityError  = perr_q;
    assign bus.framingError = ferr_q;
    assign bus.overrun      = ovr_q;
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: clean, error, false-start, overrun/handshake and reset-abort frames.
module tb_receiver;
    localparam int unsigned OS = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   lat;
    bit   ok;

    receiver_if bus ();

    receiver #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every other clock; it changes 1 time unit after the edge.
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.tick = ~bus.tick;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns just after a clock edge on which the DUT saw tick = 1.
    task automatic wait_tick();
        do @(posedge clk); while (!bus.tick);
    endtask

    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.dataIn = bits[i];
            repeat (OS) wait_tick();
        end
        bus.dataIn = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                              input logic s2);
        send_bits({s2, s1, par, d, 1'b0}, 12);
    endtask

    task automatic wait_busy(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1 found = bus.busy;
        end
    endtask

    task automatic ack();
        @(posedge clk);
        #1 bus.readAck = 1'b1;
        @(posedge clk);
        #1 bus.readAck = 1'b0;
    endtask

    task automatic settle();
        repeat (2) wait_tick();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.dataIn  = 1'b1;
        bus.readAck = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_dataOut", {24'h0, bus.dataOut}, 32'h00);
        check("rst_valid", {31'h0, bus.dataValid}, 32'h0);
        check("rst_perr", {31'h0, bus.parityError}, 32'h0);
        check("rst_ferr", {31'h0, bus.framingError}, 32'h0);
        check("rst_ovr", {31'h0, bus.overrun}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        repeat (4) wait_tick();

        // Clean byte, with commit latency measured in ticks from t0.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
            begin
                wait_busy(ok);
                check("a5_busy_rise", {31'h0, ok}, 32'h1);
                for (int i = 0; i < 400; i++) begin
                    wait_tick();
                    #1 lat++;
                    if (bus.dataValid) break;
                end
            end
        join
        settle();
        check("a5_latency", lat, 184);
        check("a5_dataOut", {24'h0, bus.dataOut}, 32'hA5);
        check("a5_valid", {31'h0, bus.dataValid}, 32'h1);
        check("a5_perr", {31'h0, bus.parityError}, 32'h0);
        check("a5_ferr", {31'h0, bus.framingError}, 32'h0);
        check("a5_busy", {31'h0, bus.busy}, 32'h0);
        ack();
        #1 check("a5_ack_valid", {31'h0, bus.dataValid}, 32'h0);

        // Parity error: 8'h01 needs parity 1, send 0.
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        settle();
        check("par_dataOut", {24'h0, bus.dataOut}, 32'h01);
        check("par_perr", {31'h0, bus.parityError}, 32'h1);
        check("par_valid", {31'h0, bus.dataValid}, 32'h1);
        check("par_ferr", {31'h0, bus.framingError}, 32'h0);
        ack();

        // Framing error: STOP1 = 0.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        settle();
        check("frm_dataOut", {24'h0, bus.dataOut}, 32'h3C);
        check("frm_ferr", {31'h0, bus.framingError}, 32'h1);
        check("frm_perr", {31'h0, bus.parityError}, 32'h0);
        ack();

        // False start: 3 ticks low, then high.
        #1 check("fs_valid_before", {31'h0, bus.dataValid}, 32'h0);
        bus.dataIn = 1'b0;
        repeat (3) wait_tick();
        bus.dataIn = 1'b1;
        #1 check("fs_busy_mid", {31'h0, bus.busy}, 32'h1);
        repeat (20) wait_tick();
        #1;
        check("fs_busy_end", {31'h0, bus.busy}, 32'h0);
        check("fs_valid", {31'h0, bus.dataValid}, 32'h0);

        // Back-to-back frames without acknowledge.
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        #1;
        check("ovr_first_data", {24'h0, bus.dataOut}, 32'h11);
        check("ovr_first_ovr", {31'h0, bus.overrun}, 32'h0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        settle();
        check("ovr_dataOut", {24'h0, bus.dataOut}, 32'h22);
        check("ovr_flag", {31'h0, bus.overrun}, 32'h1);
        check("ovr_valid", {31'h0, bus.dataValid}, 32'h1);
        ack();
        #1;
        check("ovr_ack_valid", {31'h0, bus.dataValid}, 32'h0);
        check("ovr_ack_flag", {31'h0, bus.overrun}, 32'h0);

        // readAck exactly on the commit edge of 8'h44 while 8'h33 is still unread.
        send_frame(8'h33, 1'b0, 1'b1, 1'b1);
        settle();
        check("cw_first_valid", {31'h0, bus.dataValid}, 32'h1);
        fork
            send_frame(8'h44, 1'b0, 1'b1, 1'b1);
            begin
                wait_busy(ok);
                check("cw_busy_rise", {31'h0, ok}, 32'h1);
                repeat (183) wait_tick();
                @(posedge clk);
                #1 bus.readAck = 1'b1;
                @(posedge clk);
                #1 bus.readAck = 1'b0;
            end
        join
        settle();
        check("cw_dataOut", {24'h0, bus.dataOut}, 32'h44);
        check("cw_valid", {31'h0, bus.dataValid}, 32'h1);
        check("cw_ovr", {31'h0, bus.overrun}, 32'h0);

        // Reset after data bit 3 of 8'hF0 aborts the frame.
        send_bits({1'b1, 1'b1, 1'b0, 8'hF0, 1'b0}, 5);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rmf_busy", {31'h0, bus.busy}, 32'h0);
        check("rmf_valid", {31'h0, bus.dataValid}, 32'h0);
        check("rmf_dataOut", {24'h0, bus.dataOut}, 32'h00);
        repeat (4) wait_tick();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        settle();
        check("rmf_5a_dataOut", {24'h0, bus.dataOut}, 32'h5A);
        check("rmf_5a_valid", {31'h0, bus.dataValid}, 32'h1);
        check("rmf_5a_perr", {31'h0, bus.parityError}, 32'h0);
        check("rmf_5a_ferr", {31'h0, bus.framingError}, 32'h0);
        check("rmf_5a_ovr", {31'h0, bus.overrun}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/receiver.md
# receiver

Serial receive side of the team's asynchronous serial link. It accepts the same 12-bit frame that `transmitter` produces: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit equal to XOR of the data, and 2 stop bits (1). The line idles high. The block oversamples the line using a tick strobe, checks parity and stop bits, and holds each received byte for a host-side consumer behind a valid/acknowledge handshake with overrun detection.

## Interface
- `OVERSAMPLE`, default 16: `tick` strobes per bit period. Must be even and ≥ 4.
- `clk` input, 1 bit: the single system clock. All state updates on `posedge clk`.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `tick` input, 1 bit: sample strobe at OVERSAMPLE × bit rate. It is high for one `clk` cycle per strobe.
- `dataIn` input, 1 bit: serial line, asynchronous to `clk`.
- `readAck` input, 1 bit: consumer has taken `dataOut`. Clears `dataValid` and `overrun`.
- `dataOut` output, 8 bits: last received byte.
- `dataValid` output, 1 bit: `dataOut` holds an unread byte.
- `parityError` output, 1 bit: the frame in `dataOut` had a bad parity bit.
- `framingError` output, 1 bit: the frame in `dataOut` had a 0 in either stop bit.
- `overrun` output, 1 bit: sticky flag. A byte was overwritten before it was acknowledged.
- `busy` output, 1 bit: the FSM is not in IDLE.

## Operation
- `dataIn` passes through a 2-flop synchronizer. Both flops reset to 1. All sampling uses the synchronized line `rx_s`.
- State changes occur only on `clk` edges where `tick` = 1, except for the handshake logic. The sample counter `cnt` and the bit index `idx` advance only on ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - **IDLE:** on a tick with `rx_s` = 0, go to START with `cnt` = 0.
  - **START:** on each tick, if `cnt` == OVERSAMPLE/2−1 the block checks the line.
    - If `rx_s` = 0: go to DATA with `cnt` = 0 and `idx` = 0.
    - If `rx_s` = 1: this is a false start; return to IDLE.
    - Otherwise: `cnt`++.
  - **DATA:** on a tick with `cnt` == OVERSAMPLE−1, shift `rx_s` into the shift register from the MSB side (shift right, LSB first), set `cnt` = 0, and increment `idx`. After the 8th sample, go to PARITY. On any other tick, `cnt`++.
  - **PARITY:** same sample rule. Capture the parity bit, then go to STOP1.
  - **STOP1:** same sample rule. Capture the stop-bit value, then go to STOP2.
  - **STOP2:** same sample rule. At the sample, commit the frame and go to IDLE. A 0 sampled in STOP2 does not by itself start a new frame; IDLE detects it on the next tick.
- Commit happens in one `clk` edge:
  - `dataOut` ← shift register.
  - `parityError` ← (^data) ≠ parity bit.
  - `framingError` ← (stop1 == 0) | (stop2 == 0).
  - `dataValid` ← 1.
  - Frames are committed even when they have errors.
- Handshake:
  - `readAck` with no commit in the same cycle: `dataValid` ← 0 and `overrun` ← 0.
  - Commit while `dataValid` = 1 and no `readAck`: the old data is overwritten and `overrun` ← 1.
  - Commit and `readAck` in the same cycle: the commit wins. `dataValid` stays 1 and `overrun` ← 0, because the old byte counts as consumed.
  - `readAck` while `dataValid` = 0 is ignored.
- `parityError` and `framingError` describe the frame currently in `dataOut`. They change only at commit or reset.

## Timing
- Reset values:
  - `dataOut` = 8'h00.
  - `dataValid`, `parityError`, `framingError`, `overrun` = 0.
  - `busy` = 0; FSM in IDLE; `cnt` and `idx` = 0; shift register = 0.
- An asserted `reset` in the middle of a frame aborts it immediately, with no commit. After release the block resynchronizes on the next falling edge.
- Let t0 be the tick on which IDLE sees `rx_s` = 0.
  - Start bit checked at tick t0+OVERSAMPLE/2.
  - Data bit k sampled at t0+OVERSAMPLE/2+OVERSAMPLE·(k+1).
  - Commit at t0+OVERSAMPLE/2+11·OVERSAMPLE. With OVERSAMPLE = 16 this is t0+184.
- `dataValid` rises on the `clk` edge of the commit tick.
- `busy` is high from the edge after t0 through the commit edge, and low after it.
- Input-to-`rx_s` latency is 2 `clk` cycles.
- Back-to-back frames (2 stop bits then an immediate start) must be received without loss.

## Test plan
- **Clean byte:** OVERSAMPLE = 16, send frame for 8'hA5 with parity 0 and stop bits 11 → `dataOut` = 8'hA5, `dataValid` = 1, `parityError` = 0, `framingError` = 0, commit at t0+184.
- **Parity error:** send 8'h01 with parity bit 0 → `dataOut` = 8'h01, `parityError` = 1, `dataValid` = 1.
- **Framing error:** send 8'h3C with STOP1 = 0 → `framingError` = 1, `dataOut` = 8'h3C.
- **False start:** drive line low for 3 ticks, then high → FSM returns to IDLE, `busy` falls, `dataValid` stays 0.
- **Overrun and handshake:** send 8'h11 and 8'h22 back-to-back with no `readAck` → `dataOut` = 8'h22, `overrun` = 1. Then `readAck` → `dataValid` = 0, `overrun` = 0. Also assert `readAck` on a commit cycle → `dataValid` = 1, `overrun` = 0.
- **Reset mid-frame:** assert `reset` after data bit 3 of 8'hF0, then send 8'h5A → no commit of 8'hF0, `dataOut` = 8'h5A, flags 0.
